// File: rtl/dlp_bank.sv
// dlp_bank: bank of clocked, multi-bit gated latches with preset.
//
// Latch behaviour is emulated synchronously on CLK, so there are no
// combinational loops and every output is a flop.
//
// Parameters:
//   WIDTH    data bits per channel
//   CHANNELS number of independent channels
//   INIT     value loaded into every Q bit on RESET
//   MODE     0 = LEVEL, 1 = OPEN-edge, 2 = CLOSE-edge (anything else acts as LEVEL)
//   GFILT    gate-filter length in cycles (only with DLP_BANK_GATE_FILTER_EN)
//
// Ports:
//   CLK    clock, rising edge
//   RESET  synchronous active-high reset
//   PRESET per-channel synchronous preset (Q <= all ones)
//   G      per-channel gate
//   D      data, channel c at [c*WIDTH +: WIDTH]
//   Q      registered latch outputs, same packing as D
//   CHG    per-channel one-cycle strobe, high while Q shows a new value
//
// Optional feature macro: DLP_BANK_GATE_FILTER_EN
//   When defined, each gate must be high for GFILT consecutive cycles before
//   it is treated as open.

module dlp_bank #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter logic        INIT     = 1'b1,
    parameter int unsigned MODE     = 0,
    parameter int unsigned GFILT    = 1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [CHANNELS-1:0]       PRESET,
    input  logic [CHANNELS-1:0]       G,
    input  logic [CHANNELS*WIDTH-1:0] D,
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic [CHANNELS-1:0]       CHG
);

`ifdef DLP_BANK_GATE_FILTER_EN
    localparam int unsigned CntW = $clog2(GFILT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(GFILT - 1);
`else
    // GFILT only matters when the filter is compiled in.
    logic unused_gfilt;
    assign unused_gfilt = ^GFILT;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] d_c;
        logic [WIDTH-1:0] q_q, q_d;
        logic [WIDTH-1:0] sh_q, sh_d;
        logic             gq_q;
        logic             chg_q;
        logic             ge;
        logic             rise;
        logic             fall;

        assign d_c = D[c*WIDTH +: WIDTH];

`ifdef DLP_BANK_GATE_FILTER_EN
        logic [CntW-1:0] cnt_q;

        // Gate is only honoured once it has been high for GFILT cycles.
        assign ge = G[c] & (cnt_q >= CntMax);

        // Counter ignores PRESET on purpose: preset must not restart filtering.
        always_ff @(posedge CLK) begin
            if (RESET || !G[c]) begin
                cnt_q <= '0;
            end else if (cnt_q < CntMax) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
`else
        assign ge = G[c];
`endif

        assign rise = ge & ~gq_q;
        assign fall = ~ge & gq_q;

        always_comb begin
            q_d  = q_q;
            sh_d = sh_q;
            if (PRESET[c]) begin
                q_d  = '1;
                sh_d = '1;
            end else begin
                case (MODE)
                    1: begin
                        if (rise) q_d = d_c;
                    end
                    2: begin
                        // Shadow tracks D while open; Q only moves on close.
                        if (ge)   sh_d = d_c;
                        if (fall) q_d  = sh_q;
                    end
                    default: begin
                        if (ge) q_d = d_c;
                    end
                endcase
            end
        end

        always_ff @(posedge CLK) begin
            if (RESET) begin
                q_q   <= {WIDTH{INIT}};
                sh_q  <= {WIDTH{INIT}};
                gq_q  <= 1'b0;
                chg_q <= 1'b0;
            end else begin
                q_q   <= q_d;
                sh_q  <= sh_d;
                // Also updated under preset so an edge during preset is consumed.
                gq_q  <= ge;
                chg_q <= (q_d != q_q);
            end
        end

        assign Q[c*WIDTH +: WIDTH] = q_q;
        assign CHG[c]              = chg_q;
    end

endmodule
